// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller: FSM state encoding,
// default parameter values and a counter-width helper.
package nco_ctrl_pkg;

    localparam int APR_DEF = 16;
    localparam int CW_DEF  = 16;
    localparam int LAT_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bits needed to hold values 0..n inclusive (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nco_settle_cnt.sv
// Settle counter: reloads LAT whenever the phase increment is rewritten and
// counts down on enabled cycles; the segment is valid once it reaches zero.
module nco_settle_cnt
    import nco_ctrl_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic busy,
    output logic valid
);

    localparam int W = cnt_width(LAT);

    logic [W-1:0] cnt_q, cnt_d;

    // A load wins over the enable so a rewrite during hold still restarts settling.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LAT);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valid = busy && (cnt_q == '0) && en;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller for an NCO: steps the phase increment through
// nsteps values, dwelling on each, then flushes the NCO pipeline.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int APR = APR_DEF,
    parameter int CW  = CW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [APR-1:0] cfg_start,
    input  logic [APR-1:0] cfg_step,
    input  logic [CW-1:0]  cfg_nsteps,
    input  logic [CW-1:0]  cfg_dwell,
    input  logic           start,
    input  logic           abort,
    input  logic           hold,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken_o,
    output logic [CW-1:0]  step_idx_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           seg_valid_o,
    output logic [1:0]     state_o
);

    localparam int FW = cnt_width(LAT);

    state_t         state_q, state_d;
    logic [APR-1:0] phi_q, phi_d;
    logic [APR-1:0] step_cfg_q, step_cfg_d;
    logic [CW-1:0]  nsteps_q, nsteps_d;
    logic [CW-1:0]  dwell_q, dwell_d;
    logic [CW-1:0]  step_q, step_d;
    logic [CW-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
    logic           done_q, done_d;
    logic           settle_load;
    logic           en;
    logic [CW-1:0]  dwell_last;

    assign en = !hold;
    // A dwell of zero behaves as a dwell of one.
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - CW'(1);

    always_comb begin
        state_d     = state_q;
        phi_d       = phi_q;
        step_cfg_d  = step_cfg_q;
        nsteps_d    = nsteps_q;
        dwell_d     = dwell_q;
        step_d      = step_q;
        dwell_cnt_d = dwell_cnt_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        settle_load = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            phi_d       = '0;
            step_d      = '0;
            dwell_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        step_cfg_d = cfg_step;
                        nsteps_d   = cfg_nsteps;
                        dwell_d    = cfg_dwell;
                        if (cfg_nsteps == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = RUN;
                            phi_d       = cfg_start;
                            step_d      = '0;
                            dwell_cnt_d = '0;
                            settle_load = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (dwell_cnt_q == dwell_last) begin
                            dwell_cnt_d = '0;
                            if (step_q == nsteps_q - CW'(1)) begin
                                state_d     = FLUSH;
                                flush_cnt_d = '0;
                            end else begin
                                phi_d       = phi_q + step_cfg_q;
                                step_d      = step_q + CW'(1);
                                settle_load = 1'b1;
                            end
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (en) begin
                        if (flush_cnt_q == FW'(LAT - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            flush_cnt_d = flush_cnt_q + FW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phi_q       <= '0;
            step_cfg_q  <= '0;
            nsteps_q    <= '0;
            dwell_q     <= '0;
            step_q      <= '0;
            dwell_cnt_q <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_q       <= phi_d;
            step_cfg_q  <= step_cfg_d;
            nsteps_q    <= nsteps_d;
            dwell_q     <= dwell_d;
            step_q      <= step_d;
            dwell_cnt_q <= dwell_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
        end
    end

    nco_settle_cnt #(.LAT(LAT)) u_settle (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .load  (settle_load),
        .busy  (busy_o),
        .valid (seg_valid_o)
    );

    assign phi_inc_o   = phi_q;
    assign step_idx_o  = step_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign nco_clken_o = en;
    assign state_o     = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed sweep scenarios plus randomized traffic,
// compared each cycle against a schedule-based model of the sweep.
module tb_nco_sweep_ctrl;

    localparam int APR = 16;
    localparam int CW  = 16;
    localparam int LAT = 10;
    localparam int OW  = APR + CW + 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [APR-1:0] cfg_start = '0;
    logic [APR-1:0] cfg_step = '0;
    logic [CW-1:0]  cfg_nsteps = '0;
    logic [CW-1:0]  cfg_dwell = '0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           hold = 1'b0;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken_o;
    logic [CW-1:0]  step_idx_o;
    logic           busy_o, done_o, seg_valid_o;
    logic [1:0]     state_o;
    logic [OW-1:0]  obs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.APR(APR), .CW(CW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_step(cfg_step),
        .cfg_nsteps(cfg_nsteps), .cfg_dwell(cfg_dwell), .start(start),
        .abort(abort), .hold(hold), .phi_inc_o(phi_inc_o),
        .nco_clken_o(nco_clken_o), .step_idx_o(step_idx_o), .busy_o(busy_o),
        .done_o(done_o), .seg_valid_o(seg_valid_o), .state_o(state_o)
    );

    assign obs = {phi_inc_o, step_idx_o, busy_o, done_o, seg_valid_o, nco_clken_o};

    // Model: the whole sweep is expanded into one entry per enabled cycle.
    // The front entry is what the current cycle shows; an enabled cycle consumes it.
    typedef struct {
        logic [APR-1:0] phi;
        logic [CW-1:0]  idx;
        int             settle;
    } ent_t;

    ent_t           sched_q[$];
    logic [APR-1:0] m_phi = '0;
    logic [CW-1:0]  m_idx = '0;
    logic           m_done = 1'b0;

    task automatic build_schedule();
        int d;
        ent_t e;
        d = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        for (int s = 0; s < int'(cfg_nsteps); s++) begin
            for (int i = 0; i < d; i++) begin
                e.phi = APR'(int'(cfg_start) + s * int'(cfg_step));
                e.idx = CW'(s);
                e.settle = (LAT - i > 0) ? LAT - i : 0;
                sched_q.push_back(e);
            end
        end
        for (int j = 0; j < LAT; j++) begin
            e = sched_q[sched_q.size() - 1];
            e.settle = (e.settle > 0) ? e.settle - 1 : 0;
            sched_q.push_back(e);
        end
    endtask

    task automatic model_tick();
        if (reset || abort) begin
            sched_q.delete();
            m_phi = '0;
            m_idx = '0;
            m_done = 1'b0;
        end else if (sched_q.size() != 0) begin
            m_done = 1'b0;
            if (!hold) begin
                m_phi = sched_q[0].phi;
                m_idx = sched_q[0].idx;
                void'(sched_q.pop_front());
                if (sched_q.size() == 0) m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                if (cfg_nsteps == 0) m_done = 1'b1;
                else build_schedule();
            end
        end
    endtask

    function automatic logic [OW-1:0] exp_vec();
        logic b;
        b = (sched_q.size() != 0);
        if (b)
            return {sched_q[0].phi, sched_q[0].idx, 1'b1, m_done,
                    (sched_q[0].settle == 0) && !hold, !hold};
        return {m_phi, m_idx, 1'b0, m_done, 1'b0, !hold};
    endfunction

    task automatic drive(input logic st, input logic ab, input logic ho, input logic rs);
        start = st;
        abort = ab;
        hold = ho;
        reset = rs;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [APR-1:0] s, input logic [APR-1:0] st,
                           input logic [CW-1:0] n, input logic [CW-1:0] d);
        cfg_start = s;
        cfg_step = st;
        cfg_nsteps = n;
        cfg_dwell = d;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_sweep();
        set_cfg(16'h1000, 16'h0100, 16'd4, 16'd3);
        for (int c = 0; c < 26; c++) begin
            drive(c == 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL sweep c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 4 || c == 12 || c == 23) begin
                checks++;
                if ((c == 4 && phi_inc_o !== 16'h1100) || (c == 12 && phi_inc_o !== 16'h1300)
                    || (c == 23 && (done_o !== 1'b1 || busy_o !== 1'b0))) begin
                    failures++;
                    $display("FAIL sweep_fixed c=%0d phi=%h done=%b busy=%b", c, phi_inc_o, done_o, busy_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        set_cfg(16'hFF00, 16'h0200, 16'd2, 16'd1);
        for (int c = 0; c < 16; c++) begin
            drive(c == 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL wrap c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (phi_inc_o !== ((c == 1) ? 16'hFF00 : 16'h0100)) begin
                    failures++;
                    $display("FAIL wrap_phi c=%0d got=%h", c, phi_inc_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_zero_len();
        logic seen_busy;
        seen_busy = 1'b0;
        set_cfg(16'h2222, 16'h0010, 16'd0, 16'd5);
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL zero_len c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            seen_busy = seen_busy | busy_o;
            if (c == 1) begin
                checks++;
                if (done_o !== 1'b1) begin
                    failures++;
                    $display("FAIL zero_len_done got=%b exp=1", done_o);
                end
            end
            advance();
        end
        checks++;
        if (seen_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_busy got=%b exp=0", seen_busy);
        end
        set_cfg(16'h0400, 16'h0040, 16'd3, 16'd0);
        for (int c = 0; c < 16; c++) begin
            drive(c == 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL zero_dwell c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 3) begin
                checks++;
                if (phi_inc_o !== 16'h0480 || step_idx_o !== 16'd2) begin
                    failures++;
                    $display("FAIL zero_dwell_step phi=%h idx=%0d exp=0480/2", phi_inc_o, step_idx_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_hold();
        set_cfg(16'h1000, 16'h0100, 16'd4, 16'd3);
        for (int c = 0; c < 30; c++) begin
            drive(c == 0, 1'b0, (c >= 5 && c <= 8), 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL hold c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 6 || c == 27) begin
                checks++;
                if ((c == 6 && (nco_clken_o !== 1'b0 || seg_valid_o !== 1'b0))
                    || (c == 27 && done_o !== 1'b1)) begin
                    failures++;
                    $display("FAIL hold_fixed c=%0d clken=%b segv=%b done=%b", c, nco_clken_o, seg_valid_o, done_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        seen_done = 1'b0;
        set_cfg(16'h1000, 16'h0100, 16'd4, 16'd3);
        for (int c = 0; c < 28; c++) begin
            drive(c == 0, c == 6, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL abort c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c >= 7) seen_done = seen_done | done_o;
            if (c == 7) begin
                checks++;
                if (phi_inc_o !== 16'h0 || busy_o !== 1'b0 || state_o !== 2'd0) begin
                    failures++;
                    $display("FAIL abort_idle phi=%h busy=%b state=%0d exp=0/0/0", phi_inc_o, busy_o, state_o);
                end
            end
            advance();
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_done got=%b exp=0", seen_done);
        end
        // start and abort together in IDLE: abort wins
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, c == 0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec() || (c > 0 && busy_o !== 1'b0)) begin
                failures++;
                $display("FAIL start_abort c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_reset_flush();
        set_cfg(16'h1000, 16'h0100, 16'd4, 16'd3);
        for (int c = 0; c < 20; c++) begin
            drive(c == 0, 1'b0, c == 15, c == 15);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL reset_flush c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 16) begin
                checks++;
                if (phi_inc_o !== '0 || step_idx_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_flush_vals got=%h exp=all zero", obs);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(16'h1000, 16'h0100, 16'd4, 16'd3);
        for (int c = 0; c < 26; c++) begin
            drive(c == 0 || c == 5 || c == 14, 1'b0, 1'b0, 1'b0);
            if (c == 5) cfg_start = 16'h7777;
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 23) begin
                checks++;
                if (done_o !== 1'b1 || phi_inc_o !== 16'h1300) begin
                    failures++;
                    $display("FAIL busy_start done=%b phi=%h exp=1/1300", done_o, phi_inc_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (!busy_o)
                set_cfg(APR'($urandom), APR'($urandom), CW'($urandom_range(0, 6)), CW'($urandom_range(0, 5)));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        advance();
        test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        test_sweep();
        test_wrap();
        test_zero_len();
        test_hold();
        test_abort();
        test_reset_flush();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
